// File: rtl/sync_mem_pkg.sv
// Shared types and constants for the sync_dp_mem dual-port memory.
// State encoding, byte width and read-latency limits live here.
package sync_mem_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_RD_LAT = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Out-of-range latencies fold into 1..MAX_RD_LAT so the pipe never has zero stages.
    function automatic int clamp_lat(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > MAX_RD_LAT) begin
            return MAX_RD_LAT;
        end
        return lat;
    endfunction

endpackage

// File: rtl/sync_dp_mem_if.sv
// Write/read request and response bundle for sync_dp_mem.
// The master modport drives requests; the slave modport is the memory side.
interface sync_dp_mem_if
    import sync_mem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);

    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic [WIDTH/BYTE_W-1:0]   wr_be;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [ADDR_W-1:0]         rd_addr;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_data_valid;

    logic                      init_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_data, rd_data_valid, init_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_data, rd_data_valid, init_busy
    );

endinterface

// File: rtl/sync_mem_pipe.sv
// Read-data delay line: RD_LAT registered stages of data plus valid.
// The final data stage only loads on a valid, so the output holds between reads.
module sync_mem_pipe
    import sync_mem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int LAT = clamp_lat(RD_LAT);

    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] dat_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/sync_dp_mem.sv
// Single-clock dual-port memory with byte-enabled writes, pipelined reads and a zero-fill pass after reset.
// Define SYNC_DP_MEM_BYPASS_EN for write-first same-address reads; the default build is read-first.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_INIT | clearing one word per cycle, ports not ready
//  ST_RUN  | normal operation, both ports ready
module sync_dp_mem
    import sync_mem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    sync_dp_mem_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = WIDTH / BYTE_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy, ready;
    logic              wr_acc, rd_acc;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign busy   = (state_q == ST_INIT);
    assign ready  = ~busy;
    assign wr_acc = bus.wr_valid & ready;
    assign rd_acc = bus.rd_valid & ready;

    // Array deliberately has no reset; the INIT pass is the only clearing mechanism.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) begin
                    mem[bus.wr_addr][b*BYTE_W +: BYTE_W] <= bus.wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[bus.rd_addr];
`ifdef SYNC_DP_MEM_BYPASS_EN
        if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) begin
                    rd_word[b*BYTE_W +: BYTE_W] = bus.wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
`else
        rd_word = mem[bus.rd_addr];
`endif
    end

    sync_mem_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (bus.rd_data_valid),
        .out_data  (bus.rd_data)
    );

    assign bus.wr_ready  = ready;
    assign bus.rd_ready  = ready;
    assign bus.init_busy = busy;

endmodule

// File: doc/sync_dp_mem.md
SYNC_DP_MEM -- requirements
Module: sync_dp_mem

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles, legal range 1..4.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_valid  input  1  write request.
REQ-007 wr_ready  output  1  write port can accept.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 wr_be  input  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 rd_valid  input  1  read request.
REQ-012 rd_ready  output  1  read port can accept.
REQ-013 rd_addr  input  ADDR_W  read address.
REQ-014 rd_data  output  WIDTH  read data, registered.
REQ-015 rd_data_valid  output  1  one-cycle pulse marking valid rd_data.
REQ-016 init_busy  output  1  high while the memory clear sequence runs.

Function
REQ-017 The FSM SHALL have two states, ST_INIT and ST_RUN; ST_INIT writes zero to one word per cycle, addresses 0..DEPTH-1 ascending.
REQ-018 After writing DEPTH-1, the FSM SHALL enter ST_RUN on the next edge; ST_INIT lasts exactly DEPTH cycles after reset release.
REQ-019 wr_ready and rd_ready SHALL be 0 in ST_INIT and 1 in ST_RUN; init_busy SHALL equal (state == ST_INIT).
REQ-020 A write is accepted on an edge where wr_valid && wr_ready; only bytes with wr_be set are updated; wr_be == 0 SHALL leave memory unchanged.
REQ-021 A read is accepted on an edge where rd_valid && rd_ready; rd_data SHALL present the word exactly RD_LAT cycles later with rd_data_valid = 1 for that one cycle.
REQ-022 Reads SHALL be fully pipelined: one accepted read per cycle; the output has no backpressure.
REQ-023 rd_data SHALL hold its last value while rd_data_valid = 0.
REQ-024 A read and a write may be accepted on the same edge to different addresses with no interaction.
REQ-025 For a read and a write accepted on the same edge to the same address, behaviour SHALL follow REQ-030.
REQ-026 Requests presented while not ready SHALL be ignored and have no effect.

Reset
REQ-027 While rst = 1: FSM = ST_INIT, init counter = 0, rd_data = 0, rd_data_valid = 0, all read pipeline valids = 0, wr_ready = 0, rd_ready = 0, init_busy = 1.
REQ-028 Reset asserted mid-INIT or mid-read SHALL restart INIT from address 0 and discard all in-flight reads.
REQ-029 Memory array contents SHALL NOT be reset directly; zeroing is done only by ST_INIT.

Configuration
REQ-030 Macro SYNC_DP_MEM_BYPASS_EN: when defined, a same-address read returns write-first data (enabled bytes new, others old); when undefined, it returns read-first (old) data.

Structure
REQ-031 Package sync_mem_pkg SHALL hold the state typedef (ST_INIT, ST_RUN), constant BYTE_W = 8 and constant MAX_RD_LAT = 4.
REQ-032 Sub-module sync_mem_pipe SHALL implement the RD_LAT-stage data/valid delay line with asynchronous reset on the valids.

Verification
REQ-033 Release reset with ADDR_W=4 -> init_busy high exactly 16 cycles, then rd_ready = wr_ready = 1; a read of every address returns 0x00.
REQ-034 WIDTH=16: write 0xABCD to addr 3 with be=2'b11, then 0x1200 with be=2'b10; read addr 3 with RD_LAT=2 -> rd_data = 0x12CD exactly 2 cycles after acceptance, valid for one cycle.
REQ-035 Back-to-back reads of addresses 0..7 (preloaded with addr+1) -> rd_data_valid high 8 consecutive cycles; data 1..8 in order.
REQ-036 Addr 5 holds 0x11; write 0x22 and read addr 5 on the same edge -> 0x22 with SYNC_DP_MEM_BYPASS_EN defined, 0x11 without.
REQ-037 Assert rst at INIT cycle 7 and during 2 in-flight reads -> no rd_data_valid pulse follows; after release, INIT restarts and lasts the full 16 cycles.
REQ-038 wr_valid = 1 during INIT with data 0xFF -> ignored; the post-INIT read returns 0x00.
